// File: rtl/bp_cce_lite_responder_if.sv
// Handshake bundle between the LCE/memory side and the lite coherence responder.
// slave  : responder view (requests, acks and memory responses come in; commands go out)
// master : LCE/memory view, used by whoever drives the responder
interface bp_cce_lite_responder_if #(
  parameter int paddr_width_p     = 40,
  parameter int dword_width_p     = 64,
  parameter int cce_block_width_p = 512
);
  logic                         lce_req_v_i;
  logic                         lce_req_ready_o;
  logic [1:0]                   lce_req_type_i;
  logic [paddr_width_p-1:0]     lce_req_addr_i;
  logic [dword_width_p-1:0]     lce_req_data_i;

  logic                         lce_cmd_v_o;
  logic                         lce_cmd_ready_i;
  logic [1:0]                   lce_cmd_type_o;
  logic [paddr_width_p-1:0]     lce_cmd_addr_o;
  logic [cce_block_width_p-1:0] lce_cmd_data_o;

  logic                         lce_resp_v_i;
  logic                         lce_resp_ready_o;

  logic                         mem_cmd_v_o;
  logic                         mem_cmd_ready_i;
  logic                         mem_cmd_w_o;
  logic                         mem_cmd_uc_o;
  logic [paddr_width_p-1:0]     mem_cmd_addr_o;
  logic [dword_width_p-1:0]     mem_cmd_data_o;

  logic                         mem_resp_v_i;
  logic                         mem_resp_yumi_o;
  logic [cce_block_width_p-1:0] mem_resp_data_i;

  modport slave (
    input  lce_req_v_i, lce_req_type_i, lce_req_addr_i, lce_req_data_i,
    output lce_req_ready_o,
    output lce_cmd_v_o, lce_cmd_type_o, lce_cmd_addr_o, lce_cmd_data_o,
    input  lce_cmd_ready_i,
    input  lce_resp_v_i,
    output lce_resp_ready_o,
    output mem_cmd_v_o, mem_cmd_w_o, mem_cmd_uc_o, mem_cmd_addr_o, mem_cmd_data_o,
    input  mem_cmd_ready_i,
    input  mem_resp_v_i, mem_resp_data_i,
    output mem_resp_yumi_o
  );

  modport master (
    output lce_req_v_i, lce_req_type_i, lce_req_addr_i, lce_req_data_i,
    input  lce_req_ready_o,
    input  lce_cmd_v_o, lce_cmd_type_o, lce_cmd_addr_o, lce_cmd_data_o,
    output lce_cmd_ready_i,
    output lce_resp_v_i,
    input  lce_resp_ready_o,
    input  mem_cmd_v_o, mem_cmd_w_o, mem_cmd_uc_o, mem_cmd_addr_o, mem_cmd_data_o,
    output mem_cmd_ready_i,
    output mem_resp_v_i, mem_resp_data_i,
    input  mem_resp_yumi_o
  );
endinterface

// File: rtl/bp_cce_lite_responder.sv
// Single-LCE coherence responder. Takes one LCE request at a time, performs the
// block or dword memory access, returns the result as an LCE command and, for
// cached fills, waits for the coherence ack (bounded by ack_timeout_p).
// Ports: clk_i, reset_n_i (async, active-low); bus (slave modport) carries the
// LCE req/cmd/resp and memory cmd/resp channels; busy_o, err_o (sticky ack
// timeout), txn_count_o (completed transactions, wraps).
//
// state      | meaning
// IDLE       | ready for an LCE request
// MEM_CMD    | presenting the memory command
// MEM_RESP   | waiting for / consuming the memory response
// LCE_CMD    | presenting the fill or uncached result to the LCE
// WAIT_ACK   | cached fill sent, waiting for the coherence ack
module bp_cce_lite_responder #(
  parameter int paddr_width_p     = 40,
  parameter int dword_width_p     = 64,
  parameter int cce_block_width_p = 512,
  parameter int ack_timeout_p     = 1024
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  bp_cce_lite_responder_if.slave     bus,
  output logic                       busy_o,
  output logic                       err_o,
  output logic [15:0]                txn_count_o
);

  localparam int offset_lp = $clog2(cce_block_width_p / 8);
  localparam int tmr_w_lp  = $clog2(ack_timeout_p);
  localparam logic [tmr_w_lp-1:0] tmr_load_lp = tmr_w_lp'(ack_timeout_p - 1);
  localparam logic [paddr_width_p-1:0] blk_mask_lp =
    {{(paddr_width_p - offset_lp){1'b1}}, {offset_lp{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_MEM_CMD, S_MEM_RESP, S_LCE_CMD, S_WAIT_ACK
  } state_e;

  state_e                       state_r, state_n;
  logic [1:0]                   type_r;
  logic [paddr_width_p-1:0]     addr_r;
  logic [dword_width_p-1:0]     wdata_r;
  logic [cce_block_width_p-1:0] data_r;
  logic [tmr_w_lp-1:0]          tmr_r;
  logic                         err_r;
  logic [15:0]                  txn_r;

  logic req_hs, resp_hs, ack_hs, timeout, done;

  // Handshake decodes; outputs themselves come only from state/registers.
  assign req_hs  = (state_r == S_IDLE)     & bus.lce_req_v_i;
  assign resp_hs = (state_r == S_MEM_RESP) & bus.mem_resp_v_i;
  assign ack_hs  = (state_r == S_WAIT_ACK) & bus.lce_resp_v_i;
  // Timer runs down from ack_timeout_p-1, so zero is hit on the
  // ack_timeout_p-th cycle spent in WAIT_ACK.
  assign timeout = (state_r == S_WAIT_ACK) & ~bus.lce_resp_v_i & (tmr_r == '0);
  assign done    = ack_hs |
                   ((state_r == S_LCE_CMD) & bus.lce_cmd_ready_i & type_r[1]);

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      S_IDLE:     if (bus.lce_req_v_i)     state_n = S_MEM_CMD;
      S_MEM_CMD:  if (bus.mem_cmd_ready_i) state_n = S_MEM_RESP;
      S_MEM_RESP: if (bus.mem_resp_v_i)    state_n = S_LCE_CMD;
      S_LCE_CMD:  if (bus.lce_cmd_ready_i) state_n = type_r[1] ? S_IDLE : S_WAIT_ACK;
      S_WAIT_ACK: if (ack_hs | timeout)    state_n = S_IDLE;
      default:                             state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= S_IDLE;
      type_r  <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
      data_r  <= '0;
      tmr_r   <= tmr_load_lp;
      err_r   <= 1'b0;
      txn_r   <= '0;
    end else begin
      state_r <= state_n;
      if (req_hs) begin
        type_r  <= bus.lce_req_type_i;
        // Alignment is applied once here so memory and LCE see the same address.
        addr_r  <= bus.lce_req_type_i[1] ? bus.lce_req_addr_i
                                         : (bus.lce_req_addr_i & blk_mask_lp);
        wdata_r <= bus.lce_req_data_i;
      end
      if (resp_hs) begin
        if (type_r == 2'd3)
          data_r <= '0;
        else if (type_r[1])
          data_r <= {{(cce_block_width_p - dword_width_p){1'b0}},
                     bus.mem_resp_data_i[dword_width_p-1:0]};
        else
          data_r <= bus.mem_resp_data_i;
      end
      if (state_r != S_WAIT_ACK)
        tmr_r <= tmr_load_lp;
      else if (!bus.lce_resp_v_i && tmr_r != '0)
        tmr_r <= tmr_r - 1'b1;
      if (timeout) err_r <= 1'b1;
      if (done)    txn_r <= txn_r + 16'd1;
    end
  end

  assign bus.lce_req_ready_o  = (state_r == S_IDLE);
  assign bus.mem_cmd_v_o      = (state_r == S_MEM_CMD);
  assign bus.mem_cmd_w_o      = (type_r == 2'd3);
  assign bus.mem_cmd_uc_o     = type_r[1];
  assign bus.mem_cmd_addr_o   = addr_r;
  assign bus.mem_cmd_data_o   = wdata_r;
  assign bus.mem_resp_yumi_o  = resp_hs;
  assign bus.lce_cmd_v_o      = (state_r == S_LCE_CMD);
  assign bus.lce_cmd_type_o   = type_r;
  assign bus.lce_cmd_addr_o   = addr_r;
  assign bus.lce_cmd_data_o   = data_r;
  assign bus.lce_resp_ready_o = (state_r == S_WAIT_ACK);

  assign busy_o      = (state_r != S_IDLE);
  assign err_o       = err_r;
  assign txn_count_o = txn_r;

endmodule

// File: tb/tb_bp_cce_lite_responder.sv
module tb_bp_cce_lite_responder;
  localparam int PA = 40;
  localparam int DW = 64;
  localparam int BW = 512;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  logic busy_o, err_o;
  logic [15:0] txn_count_o;

  always #5 clk_i = ~clk_i;

  bp_cce_lite_responder_if #(.paddr_width_p(PA), .dword_width_p(DW), .cce_block_width_p(BW)) ifc ();

  bp_cce_lite_responder #(
    .paddr_width_p(PA), .dword_width_p(DW), .cce_block_width_p(BW), .ack_timeout_p(8)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .bus(ifc.slave),
    .busy_o(busy_o), .err_o(err_o), .txn_count_o(txn_count_o)
  );

  typedef struct packed { logic w; logic uc; logic [PA-1:0] addr; logic [DW-1:0] data; } mem_exp_t;
  typedef struct packed { logic [1:0] typ; logic [PA-1:0] addr; logic [BW-1:0] data; } lce_exp_t;

  mem_exp_t mem_q[$];
  lce_exp_t lce_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // environment knobs
  int mem_cmd_stall = 0, mem_resp_stall = 0, lce_stall = 0, ack_delay = 0;
  bit ack_en = 1, resp_hold = 0;
  logic [BW-1:0] mem_rdata = '0;

  // monitor bookkeeping
  int mem_hs_cyc = 0, lce_hs_cyc = 0, mem_hs_cnt = 0, lce_hs_cnt = 0, acc_cyc = 0;
  int resp_ready_seen = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", nm);
  endtask

  function automatic logic [BW-1:0] make_block(input logic [31:0] seed);
    logic [BW-1:0] b;
    for (int i = 0; i < BW / 64; i++) b[i*64 +: 64] = {seed, 32'(i)};
    return b;
  endfunction

  // ---------------- memory model ----------------
  initial begin
    bit cmd_hs, rsp_hs, rsp_pending;
    int cmd_wait, rsp_wait;
    cmd_wait = 0; rsp_wait = 0; rsp_pending = 0;
    ifc.mem_cmd_ready_i = 1'b0;
    ifc.mem_resp_v_i    = 1'b0;
    ifc.mem_resp_data_i = '0;
    forever begin
      @(negedge clk_i);
      cmd_hs = ifc.mem_cmd_v_o && ifc.mem_cmd_ready_i;
      rsp_hs = ifc.mem_resp_v_i && ifc.mem_resp_yumi_o;
      @(posedge clk_i); #1;
      if (cmd_hs) begin ifc.mem_cmd_ready_i = 1'b0; rsp_pending = 1; rsp_wait = 0; end
      if (rsp_hs) ifc.mem_resp_v_i = 1'b0;
      if (ifc.mem_cmd_v_o && !ifc.mem_cmd_ready_i) begin
        if (cmd_wait >= mem_cmd_stall) begin ifc.mem_cmd_ready_i = 1'b1; cmd_wait = 0; end
        else cmd_wait++;
      end
      if (rsp_pending) begin
        if (rsp_wait >= mem_resp_stall) begin
          ifc.mem_resp_v_i = 1'b1; ifc.mem_resp_data_i = mem_rdata; rsp_pending = 0;
        end else rsp_wait++;
      end
    end
  end

  // ---------------- LCE command sink / ack source ----------------
  initial begin
    bit l_hs, a_hs, ack_pending;
    logic [1:0] l_type;
    int l_wait, a_wait;
    l_wait = 0; a_wait = 0; ack_pending = 0;
    ifc.lce_cmd_ready_i = 1'b0;
    ifc.lce_resp_v_i    = 1'b0;
    forever begin
      @(negedge clk_i);
      l_hs   = ifc.lce_cmd_v_o && ifc.lce_cmd_ready_i;
      l_type = ifc.lce_cmd_type_o;
      a_hs   = ifc.lce_resp_v_i && ifc.lce_resp_ready_o;
      @(posedge clk_i); #1;
      if (l_hs) begin
        ifc.lce_cmd_ready_i = 1'b0;
        if (!l_type[1] && ack_en) begin ack_pending = 1; a_wait = 0; end
      end
      if (a_hs && !resp_hold) ifc.lce_resp_v_i = 1'b0;
      if (ifc.lce_cmd_v_o && !ifc.lce_cmd_ready_i) begin
        if (l_wait >= lce_stall) begin ifc.lce_cmd_ready_i = 1'b1; l_wait = 0; end
        else l_wait++;
      end
      if (ack_pending) begin
        if (a_wait >= ack_delay) begin ifc.lce_resp_v_i = 1'b1; ack_pending = 0; end
        else a_wait++;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  mem_exp_t prev_mem;
  lce_exp_t prev_lce;
  bit prev_mem_stall = 0, prev_lce_stall = 0;

  always @(negedge clk_i) begin
    mem_exp_t cm, em;
    lce_exp_t cl, el;
    cm = '{ifc.mem_cmd_w_o, ifc.mem_cmd_uc_o, ifc.mem_cmd_addr_o, ifc.mem_cmd_data_o};
    cl = '{ifc.lce_cmd_type_o, ifc.lce_cmd_addr_o, ifc.lce_cmd_data_o};
    if (resp_hold && ifc.lce_resp_ready_o) resp_ready_seen++;

    if (ifc.mem_cmd_v_o && prev_mem_stall) chk("mem_cmd_stable", BW'(cm), BW'(prev_mem));
    prev_mem_stall = ifc.mem_cmd_v_o && !ifc.mem_cmd_ready_i;
    prev_mem = cm;
    if (ifc.lce_cmd_v_o && prev_lce_stall) chk("lce_cmd_stable", BW'(cl), BW'(prev_lce));
    prev_lce_stall = ifc.lce_cmd_v_o && !ifc.lce_cmd_ready_i;
    prev_lce = cl;

    if (ifc.mem_cmd_v_o && ifc.mem_cmd_ready_i) begin
      mem_hs_cyc = cyc; mem_hs_cnt++;
      if (mem_q.size() == 0) flag("mem_cmd_unexpected");
      else begin
        em = mem_q.pop_front();
        chk("mem_cmd_w", BW'(cm.w), BW'(em.w));
        chk("mem_cmd_uc", BW'(cm.uc), BW'(em.uc));
        chk("mem_cmd_addr", BW'(cm.addr), BW'(em.addr));
        chk("mem_cmd_data", BW'(cm.data), BW'(em.data));
      end
    end
    if (ifc.lce_cmd_v_o && ifc.lce_cmd_ready_i) begin
      lce_hs_cyc = cyc; lce_hs_cnt++;
      if (lce_q.size() == 0) flag("lce_cmd_unexpected");
      else begin
        el = lce_q.pop_front();
        chk("lce_cmd_type", BW'(cl.typ), BW'(el.typ));
        chk("lce_cmd_addr", BW'(cl.addr), BW'(el.addr));
        chk("lce_cmd_data", cl.data, el.data);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic expect_txn(input logic [1:0] t, input logic [PA-1:0] a, input logic [DW-1:0] d,
                            input logic [BW-1:0] ldata);
    mem_q.push_back('{(t == 2'd3), t[1], a, d});
    lce_q.push_back('{t, a, ldata});
  endtask

  task automatic send_req(input logic [1:0] t, input logic [PA-1:0] a, input logic [DW-1:0] d,
                          input logic [BW-1:0] md);
    int n;
    mem_rdata = md;
    @(posedge clk_i); #1;
    ifc.lce_req_v_i = 1'b1; ifc.lce_req_type_i = t;
    ifc.lce_req_addr_i = a; ifc.lce_req_data_i = d;
    n = 0;
    forever begin
      @(negedge clk_i);
      if (ifc.lce_req_ready_o) begin acc_cyc = cyc; break; end
      if (++n > 200) begin flag("req_accept_timeout"); break; end
    end
    @(posedge clk_i); #1;
    ifc.lce_req_v_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk_i);
    while (busy_o) begin
      @(negedge clk_i);
      if (++n > 500) begin flag("idle_timeout"); break; end
    end
  endtask

  task automatic wait_lce_hs(input int prev);
    int n;
    n = 0;
    while (lce_hs_cnt <= prev) begin
      @(negedge clk_i);
      if (++n > 500) begin flag("lce_hs_timeout"); break; end
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_i);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [BW-1:0] blk;
    int p_lce, p_mem, n;

    ifc.lce_req_v_i = 1'b0; ifc.lce_req_type_i = '0;
    ifc.lce_req_addr_i = '0; ifc.lce_req_data_i = '0;
    #12;
    chk("rst_req_ready", BW'(ifc.lce_req_ready_o), BW'(1'b1));
    chk("rst_valids", BW'({ifc.mem_cmd_v_o, ifc.lce_cmd_v_o, ifc.lce_resp_ready_o, ifc.mem_resp_yumi_o}), '0);
    chk("rst_status", BW'({busy_o, err_o, txn_count_o}), '0);
    chk("rst_latched", BW'({ifc.mem_cmd_addr_o, ifc.lce_cmd_addr_o}) | ifc.lce_cmd_data_o, '0);
    @(posedge clk_i); #3; reset_n_i = 1'b1;

    // 1: uncached read, zero-wait, latency check
    blk = make_block(32'h1111_1111);
    blk[63:0] = 64'h0000_0000_DEAD_BEEF;
    expect_txn(2'd2, 40'h80001008, '0, BW'(64'hDEAD_BEEF));
    send_req(2'd2, 40'h80001008, '0, blk);
    wait_until(acc_cyc + 4);
    chk("uc_rd_idle_t4", BW'(busy_o), BW'(1'b0));
    chk("uc_rd_txn", BW'(txn_count_o), BW'(16'd1));
    chk("uc_rd_mem_lat", BW'(mem_hs_cyc - acc_cyc), BW'(1));
    chk("uc_rd_lce_lat", BW'(lce_hs_cyc - acc_cyc), BW'(3));

    // 2: read miss, block aligned, ack arrives late
    ack_delay = 3;
    blk = make_block(32'hA5A5_0001);
    expect_txn(2'd0, 40'h80001040, '0, blk);
    p_lce = lce_hs_cnt;
    send_req(2'd0, 40'h8000107C, '0, blk);
    wait_lce_hs(p_lce);
    wait_until(lce_hs_cyc + 3);
    chk("rd_miss_busy_wait_ack", BW'(busy_o), BW'(1'b1));
    chk("rd_miss_resp_ready", BW'(ifc.lce_resp_ready_o), BW'(1'b1));
    wait_idle();
    chk("rd_miss_txn", BW'(txn_count_o), BW'(16'd2));
    ack_delay = 0;

    // 3: uncached write, held ack never consumed
    resp_hold = 1;
    @(posedge clk_i); #1; ifc.lce_resp_v_i = 1'b1;
    expect_txn(2'd3, 40'h80002010, 64'h1234, '0);
    send_req(2'd3, 40'h80002010, 64'h1234, make_block(32'hFFFF_0003));
    wait_idle();
    chk("uc_wr_ack_not_consumed", BW'(resp_ready_seen), BW'(0));
    chk("uc_wr_txn", BW'(txn_count_o), BW'(16'd3));
    @(posedge clk_i); #1; ifc.lce_resp_v_i = 1'b0; resp_hold = 0;

    // 4: backpressure on every channel
    mem_cmd_stall = 5; mem_resp_stall = 5; lce_stall = 5;
    blk = make_block(32'h0BAD_C0DE);
    p_lce = lce_hs_cnt; p_mem = mem_hs_cnt;
    expect_txn(2'd1, 40'h80003000, 64'h77, blk);
    send_req(2'd1, 40'h80003005, 64'h77, blk);
    wait_idle();
    chk("bp_one_mem_cmd", BW'(mem_hs_cnt - p_mem), BW'(1));
    chk("bp_one_lce_cmd", BW'(lce_hs_cnt - p_lce), BW'(1));
    chk("bp_txn", BW'(txn_count_o), BW'(16'd4));
    mem_cmd_stall = 0; mem_resp_stall = 0; lce_stall = 0;

    // 5: write miss, no ack -> timeout after 8 cycles in WAIT_ACK
    ack_en = 0;
    blk = make_block(32'h5555_0005);
    p_lce = lce_hs_cnt;
    expect_txn(2'd1, 40'h80004000, '0, blk);
    send_req(2'd1, 40'h80004010, '0, blk);
    wait_lce_hs(p_lce);
    wait_until(lce_hs_cyc + 8);
    chk("to_err_before", BW'({err_o, busy_o}), BW'(2'b01));
    @(negedge clk_i);
    chk("to_err_after", BW'({err_o, busy_o}), BW'(2'b10));
    chk("to_txn_unchanged", BW'(txn_count_o), BW'(16'd4));
    ack_en = 1;

    // 6: async reset while in LCE_CMD
    lce_stall = 20;
    expect_txn(2'd2, 40'h80005000, '0, BW'(64'h55));
    send_req(2'd2, 40'h80005000, '0, BW'(64'h55));
    n = 0;
    while (!ifc.lce_cmd_v_o && n < 100) begin @(negedge clk_i); n++; end
    chk("rst6_reached_lce_cmd", BW'(ifc.lce_cmd_v_o), BW'(1'b1));
    #2; reset_n_i = 1'b0; #1;
    chk("rst6_valids_drop", BW'({ifc.lce_cmd_v_o, ifc.mem_cmd_v_o, ifc.lce_resp_ready_o, ifc.mem_resp_yumi_o}), '0);
    chk("rst6_status", BW'({busy_o, err_o, txn_count_o}), '0);
    chk("rst6_req_ready", BW'(ifc.lce_req_ready_o), BW'(1'b1));
    lce_q.delete();
    lce_stall = 0;
    @(posedge clk_i); @(posedge clk_i); #3; reset_n_i = 1'b1;
    expect_txn(2'd2, 40'h80006008, '0, BW'(64'h0123_4567_89AB_CDEF));
    send_req(2'd2, 40'h80006008, '0, {make_block(32'h9999_0006)} & ~BW'({DW{1'b1}}) | BW'(64'h0123_4567_89AB_CDEF));
    wait_idle();
    chk("rst6_new_txn", BW'(txn_count_o), BW'(16'd1));

    repeat (3) @(negedge clk_i);
    chk("sb_mem_q_empty", BW'(mem_q.size()), '0);
    chk("sb_lce_q_empty", BW'(lce_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bp_cce_lite_responder.md
# bp_cce_lite_responder

Single-LCE coherence responder: the directory-side end of the LCE request/command/response protocol that the core's cache LCEs drive. It accepts one LCE request at a time and fetches or writes the line through a simple memory command/response port. It then returns the fill or uncached result as an LCE command and, for cached fills, waits for the LCE's coherence ack before accepting the next request. It is used in single-core bring-up configurations in place of the full microcoded CCE.

## Interface
Parameters:
- paddr_width_p, 40: physical address width.
- dword_width_p, 64: uncached data width.
- cce_block_width_p, 512: cache block width. Must be a power of two and at least 2×dword.
- ack_timeout_p, 1024: maximum cycles spent in WAIT_ACK before the error flag is raised. Must be at least 2.

Ports:
- Clock and reset. One clock; reset is asynchronous and active-low.
  - clk_i  in  1  clock.
  - reset_n_i  in  1  asynchronous, active-low reset.
- LCE request channel:
  - lce_req_v_i  in  1  request valid.
  - lce_req_ready_o  out  1  request ready.
  - lce_req_type_i  in  2  request type: 0 read miss, 1 write miss, 2 uncached read, 3 uncached write.
  - lce_req_addr_i  in  paddr_width_p  request address.
  - lce_req_data_i  in  dword_width_p  uncached write data.
- LCE command channel:
  - lce_cmd_v_o  out  1  command valid.
  - lce_cmd_ready_i  in  1  command ready.
  - lce_cmd_type_o  out  2  command type: 0 fill shared, 1 fill exclusive, 2 uncached data, 3 uncached write done.
  - lce_cmd_addr_o  out  paddr_width_p  command address.
  - lce_cmd_data_o  out  cce_block_width_p  command data.
- LCE response channel:
  - lce_resp_v_i  in  1  coherence ack valid.
  - lce_resp_ready_o  out  1  coherence ack ready.
- Memory command channel:
  - mem_cmd_v_o  out  1  memory command valid.
  - mem_cmd_ready_i  in  1  memory command ready.
  - mem_cmd_w_o  out  1  1 = write.
  - mem_cmd_uc_o  out  1  1 = dword access, 0 = block access.
  - mem_cmd_addr_o  out  paddr_width_p  memory address.
  - mem_cmd_data_o  out  dword_width_p  write data.
- Memory response channel:
  - mem_resp_v_i  in  1  memory response valid.
  - mem_resp_yumi_o  out  1  memory response consumed.
  - mem_resp_data_i  in  cce_block_width_p  response data. Uncached data is in bits [dword-1:0].
- Status:
  - busy_o  out  1  high whenever the FSM is not in IDLE.
  - err_o  out  1  sticky ack-timeout flag.
  - txn_count_o  out  16  count of completed transactions; wraps.

## Operation
- FSM states: IDLE, MEM_CMD, MEM_RESP, LCE_CMD, WAIT_ACK.
- IDLE:
  - lce_req_ready_o=1.
  - On lce_req_v_i, latch type, address and data, then go to MEM_CMD.
- MEM_CMD:
  - mem_cmd_v_o=1, with mem_cmd_w_o=(type==3) and mem_cmd_uc_o=type[1].
  - For cached types, the address is block-aligned: low log2(cce_block_width_p/8) bits cleared. Uncached types pass the address through unchanged.
  - On mem_cmd_ready_i, go to MEM_RESP.
- MEM_RESP:
  - mem_resp_yumi_o = mem_resp_v_i.
  - On the handshake, latch data: the full block if cached; the low dword zero-extended if uncached. An uncached write still requires a response, and its data is ignored.
  - Go to LCE_CMD.
- LCE_CMD:
  - lce_cmd_v_o=1, with type mapped 0→0, 1→1, 2→2, 3→3.
  - Address is the same value sent to memory. Data is the latched data (zero for type 3).
  - On lce_cmd_ready_i: go to WAIT_ACK if cached, otherwise go to IDLE and increment txn_count_o.
- WAIT_ACK:
  - lce_resp_ready_o=1.
  - On lce_resp_v_i, go to IDLE and increment txn_count_o.
  - A timeout counter clears on entry and increments each cycle without an ack. When it reaches ack_timeout_p-1 with no ack, set err_o, go to IDLE, and do not increment txn_count_o.
- Ready gating: lce_req_ready_o and lce_resp_ready_o are 0 outside their states. Acks arriving in other states are not consumed.
- err_o clears only on reset.

## Timing
- Reset (asynchronous, reset_n_i=0):
  - State is IDLE.
  - All valid, ready and yumi outputs are 0, except lce_req_ready_o, which is 1 because it is decoded from IDLE.
  - busy_o=0, err_o=0, txn_count_o=0.
  - Latched data and address are 0.
- Reset assertion mid-transaction aborts it immediately. No handshake outputs remain asserted.
- All outputs are decoded from state or registers only. There is no combinational path from any _i to any _o except mem_resp_yumi_o = state==MEM_RESP & mem_resp_v_i.
- Minimum latency with zero-wait memory:
  - Request accepted at cycle t.
  - mem_cmd_v_o at t+1.
  - Response consumed at t+2.
  - lce_cmd_v_o at t+3.
  - Uncached transactions return to IDLE at t+4. The next request can be accepted at t+4.
- Valid outputs hold stable until their handshake completes. Their payload does not change while valid.
- txn_count_o updates the cycle after the final handshake. It wraps from 0xFFFF to 0.

## Test plan
- Uncached read, addr 0x80001008, zero-wait memory:
  - mem_cmd at t+1 with uc=1, w=0, addr 0x80001008.
  - Memory returns dword 0xDEADBEEF → lce_cmd type 2 at t+3, data 0x...0DEADBEEF (zero-extended).
  - txn_count_o=1.
- Read miss, addr 0x8000107C, block 512:
  - mem_cmd uc=0, addr 0x80001040.
  - lce_cmd type 0, full block.
  - busy_o stays 1 until the ack; the ack returns the FSM to IDLE.
- Uncached write, data 0x1234:
  - mem_cmd w=1, data 0x1234.
  - lce_cmd type 3, data 0.
  - No ack is awaited; lce_resp_v_i held high is never consumed.
- Backpressure: mem_cmd_ready_i, mem_resp_v_i and lce_cmd_ready_i each stalled 5 cycles → valid and payload held stable, and exactly one transaction completes.
- Ack timeout: write miss with ack_timeout_p=8 and no ack → err_o=1 after 8 cycles in WAIT_ACK, FSM in IDLE, txn_count_o unchanged.
- Asynchronous reset asserted in LCE_CMD → all valid outputs drop immediately. After release, the FSM is in IDLE and a new request completes normally.
